ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Sits downstream of the PS2 controller's received-byte interface (`received_data` / `received_data_en`).
- Parses the set-2 scan-code stream, including the E0 extended and F0 break prefixes and the E1 Pause sequence.
- Produces key make/break events through a parametrised FIFO with a valid/ready handshake.
- Maintains a parametrised table of simultaneously held keys, so game logic can test any key, not only the last one or two.

Parameters:
- NUM_SLOTS, 4, number of simultaneously tracked held keys (1..16).
- FIFO_DEPTH, 8, event FIFO entries; power of 2, 2..64.
- TIMEOUT_CYCLES, 1000000, idle cycles after which a half-received prefix sequence is abandoned (20 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from the PS2 controller.
- rx_valid  in  1  single-cycle strobe; rx_data is valid while it is high.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer pops the head entry when evt_valid && evt_ready.
- evt_data  out  10  head entry: {make, ext, code[7:0]}.
- evt_count  out  $clog2(FIFO_DEPTH+1)  number of FIFO entries.
- slot_keys  out  NUM_SLOTS*9  per-slot {ext, code}; slot i occupies bits [9i+8:9i].
- slot_valid  out  NUM_SLOTS  slot occupied.
- held_any  out  1  OR of slot_valid.
- query_ext  in  1  key lookup, extended bit.
- query_code  in  8  key lookup, scan code.
- query_held  out  1  combinational: some valid slot matches {query_ext, query_code}.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
- clear_overflow  in  1  clears overflow. If a new drop occurs in the same cycle, the set wins.
- table_full  out  1  one-cycle pulse when a make event finds no free slot.

Behaviour:
- Reset (resetn=0, asynchronous, any state):
  - parser returns to IDLE;
  - FIFO empties, with evt_valid=0 and evt_count=0;
  - slot_valid=0 and slot_keys=0;
  - overflow=0 and table_full=0;
  - timeout counter cleared.
  - A reset mid-sequence discards all partial prefixes.
- Parser FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Each transition happens on a cycle with rx_valid=1.
  - IDLE:
    - E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip counter set to 7.
    - AA, FA, FE, EE, 00, FF -> dropped, stay in IDLE.
    - Any other byte -> emit make {1,0,byte}.
  - EXT: F0 -> EXT_BRK; E0/E1 -> restart as if seen in IDLE; any other byte -> emit make {1,1,byte} and go to IDLE.
  - BRK: any byte -> emit break {0,0,byte}, go to IDLE. An F0 or E0 byte here is treated as a protocol error: nothing emitted, go to IDLE.
  - EXT_BRK: any byte -> emit break {0,1,byte}, go to IDLE. The same F0/E0 error rule applies.
  - PAUSE: consume 7 further bytes, then emit make {1,1,8'h77} and go to IDLE. Pause produces no break event.
- Timeout: in any non-IDLE state, TIMEOUT_CYCLES consecutive cycles without rx_valid force IDLE and emit nothing. The counter resets on every rx_valid.
- Latency: an event emitted on the byte cycle N appears in the FIFO (evt_valid, evt_data) and in the slot table at N+1.
- FIFO:
  - Show-ahead: evt_data always presents the head entry.
  - Push and pop in the same cycle are both performed, including when the FIFO is full.
  - A push while full with no pop drops the event and sets overflow.
  - The slot table is updated regardless of whether the FIFO accepted the event.
- Slot table:
  - Make, key already present -> no change.
  - Make, key absent -> write to the lowest-index free slot.
  - Make, no free slot -> table_full pulse, nothing stored.
  - Break, key present -> clear that slot's valid bit and zero its key.
  - Break, key absent -> ignored.
  - At most one slot can ever match a given key.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined: a make event for a key already held is not pushed to the FIFO, so auto-repeat bytes are suppressed and only the first press is reported.
- Undefined: every make event is pushed, including typematic repeats.
- The slot table behaviour is identical in both builds.

Decomposition:
- Package ps2_pkg contains:
  - the parser state enum;
  - localparams for the E0, F0, E1, AA, FA, FE, EE bytes and the pause code 77;
  - the event type {make, ext, code} and its width constant EVT_W=10.
- One sub-module, ps2_evt_fifo:
  - parametrised depth and width;
  - show-ahead output, count, and full/empty flags;
  - asynchronous active-low reset.
- Parser and slot table stay in the top level.

Test Plan:
- Bytes 1D, then F0 1D, with evt_ready=1 -> events {1,0,1D} then {0,0,1D}; slot0 = {0,1D} after the first event and clear after the second; held_any 1 -> 0.
- Bytes E0 75, then E0 F0 75 -> events {1,1,75} and {0,1,75}; query_ext=1, query_code=75 gives query_held=1 between the two events, and 0 with query_ext=0.
- Default NUM_SLOTS=4, makes for 1C 1B 23 2B 34 -> fifth make gives a table_full pulse; after F0 1B, make 34 lands in slot1.
- evt_ready=0, 9 distinct makes with FIFO_DEPTH=8 -> evt_count=8, overflow=1, head still the first key. Then assert evt_ready and clear_overflow together on a cycle with a new push -> push accepted, count stays 8, overflow cleared.
- Stream E1 14 77 E1 F0 14 F0 77 -> exactly one event {1,1,77}. Separately, byte E0 then 1000000 idle cycles, then 1C -> event {1,0,1C}.
- Make 1C sent 3 times -> 3 events without PS2_TYPEMATIC_FILTER_EN, 1 event with it; in both builds only slot0 is occupied. Deassert resetn mid-way through E0 F0 -> all outputs zero immediately.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 key tracker.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } ps2_state_e;

  localparam logic [7:0] B_E0       = 8'hE0;
  localparam logic [7:0] B_F0       = 8'hF0;
  localparam logic [7:0] B_E1       = 8'hE1;
  localparam logic [7:0] B_AA       = 8'hAA;
  localparam logic [7:0] B_FA       = 8'hFA;
  localparam logic [7:0] B_FE       = 8'hFE;
  localparam logic [7:0] B_EE       = 8'hEE;
  localparam logic [7:0] PAUSE_CODE = 8'h77;

  localparam int EVT_W = 10;

  typedef struct packed {
    logic       make;
    logic       ext;
    logic [7:0] code;
  } ps2_evt_t;

  // Controller status/ack bytes and line noise that never carry a key.
  function automatic logic is_drop(input logic [7:0] b);
    return (b == B_AA) || (b == B_FA) || (b == B_FE) || (b == B_EE) ||
           (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only when a pop happens in the same cycle.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [W-1:0]                 data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Set-2 scan-code parser, held-key slot table and event FIFO.
// Build option PS2_TYPEMATIC_FILTER_EN: suppress FIFO pushes of makes for keys already held.
//   state      | meaning
//   ST_IDLE    | waiting for first byte of a code
//   ST_EXT     | E0 seen
//   ST_BRK     | F0 seen
//   ST_EXT_BRK | E0 F0 seen
//   ST_PAUSE   | E1 seen, skipping the rest of the Pause sequence
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                              CLOCK_50,
  input  logic                              resetn,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [EVT_W-1:0]                  evt_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   evt_count,
  output logic [NUM_SLOTS*9-1:0]            slot_keys,
  output logic [NUM_SLOTS-1:0]              slot_valid,
  output logic                              held_any,
  input  logic                              query_ext,
  input  logic [7:0]                        query_code,
  output logic                              query_held,
  output logic                              overflow,
  input  logic                              clear_overflow,
  output logic                              table_full
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e     state_q, state_d;
  logic [2:0]     skip_q, skip_d;
  logic [TW-1:0]  tmo_q;
  logic           emit;
  ps2_evt_t       evt_d;

  logic [8:0]           key_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] vld_q, match, free_oh;
  logic                 present, free_any, found;
  logic                 overflow_q, tfull_q;
  logic                 fifo_push, fifo_full, fifo_empty, fifo_pop;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    evt_d   = '0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE, ST_EXT: begin
          if (rx_data == B_E0) begin
            state_d = ST_EXT;
          end else if (rx_data == B_E1) begin
            state_d = ST_PAUSE;
            skip_d  = 3'd7;
          end else if (rx_data == B_F0) begin
            state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
          end else if (state_q == ST_IDLE && is_drop(rx_data)) begin
            state_d = ST_IDLE;
          end else begin
            emit       = 1'b1;
            evt_d.make = 1'b1;
            evt_d.ext  = (state_q == ST_EXT);
            evt_d.code = rx_data;
            state_d    = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (rx_data != B_F0 && rx_data != B_E0) begin
            emit       = 1'b1;
            evt_d.ext  = (state_q == ST_EXT_BRK);
            evt_d.code = rx_data;
          end
        end
        ST_PAUSE: begin
          if (skip_q == 3'd1) begin
            emit       = 1'b1;
            evt_d.make = 1'b1;
            evt_d.ext  = 1'b1;
            evt_d.code = PAUSE_CODE;
            state_d    = ST_IDLE;
          end else begin
            skip_d = skip_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == '0) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      if (rx_valid || state_q == ST_IDLE) tmo_q <= TW'(TIMEOUT_CYCLES - 1);
      else if (tmo_q != '0)               tmo_q <= tmo_q - 1'b1;
    end
  end

  always_comb begin
    match      = '0;
    free_oh    = '0;
    found      = 1'b0;
    query_held = 1'b0;
    slot_keys  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      match[i] = vld_q[i] && (key_q[i] == {evt_d.ext, evt_d.code});
      if (vld_q[i] && key_q[i] == {query_ext, query_code}) query_held = 1'b1;
      if (!vld_q[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
      slot_keys[9*i +: 9] = key_q[i];
    end
    present  = |match;
    free_any = found;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_SLOTS; i++) key_q[i] <= '0;
      vld_q   <= '0;
      tfull_q <= 1'b0;
    end else begin
      tfull_q <= 1'b0;
      if (emit && evt_d.make && !present) begin
        if (free_any) begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (free_oh[i]) begin
              vld_q[i] <= 1'b1;
              key_q[i] <= {evt_d.ext, evt_d.code};
            end
          end
        end else begin
          tfull_q <= 1'b1;
        end
      end else if (emit && !evt_d.make) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (match[i]) begin
            vld_q[i] <= 1'b0;
            key_q[i] <= '0;
          end
        end
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign fifo_push = emit && !(evt_d.make && present);
`else
  assign fifo_push = emit;
`endif
  assign fifo_pop = evt_ready && !fifo_empty;

  // A drop that coincides with clear_overflow must still leave the flag set.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)                                   overflow_q <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop)  overflow_q <= 1'b1;
    else if (clear_overflow)                       overflow_q <= 1'b0;
  end

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(EVT_W)) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_ni  (resetn),
    .push_i  (fifo_push),
    .data_i  (evt_d),
    .pop_i   (evt_ready),
    .data_o  (evt_data),
    .count_o (evt_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid  = !fifo_empty;
  assign slot_valid = vld_q;
  assign held_any   = |vld_q;
  assign overflow   = overflow_q;
  assign table_full = tfull_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker; honours PS2_TYPEMATIC_FILTER_EN for the repeat-make expectation.
module tb_ps2_key_tracker;
  localparam int NS = 4;
  localparam int FD = 8;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        evt_valid;
  logic        evt_ready;
  logic [9:0]  evt_data;
  logic [3:0]  evt_count;
  logic [NS*9-1:0] slot_keys;
  logic [NS-1:0]   slot_valid;
  logic        held_any;
  logic        query_ext;
  logic [7:0]  query_code;
  logic        query_held;
  logic        overflow;
  logic        clear_overflow;
  logic        table_full;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ps2_key_tracker #(.NUM_SLOTS(NS), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50       (clk),
    .resetn         (resetn),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_data       (evt_data),
    .evt_count      (evt_count),
    .slot_keys      (slot_keys),
    .slot_valid     (slot_valid),
    .held_any       (held_any),
    .query_ext      (query_ext),
    .query_code     (query_code),
    .query_held     (query_held),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .table_full     (table_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one byte for exactly one rising edge and returns at the next negedge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; rx_data = '0; rx_valid = 1'b0; evt_ready = 1'b1;
    query_ext = 1'b0; query_code = '0; clear_overflow = 1'b0;
    idle(2);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_count", 32'(evt_count), 32'd0);
    chk("rst_slot_valid", 32'(slot_valid), 32'd0);
    chk("rst_slot_keys", 32'(slot_keys), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_table_full", 32'(table_full), 32'd0);
    resetn = 1'b1;
    idle(1);

    // Plain make and break
    send(8'h1D);
    chk("mk_valid", 32'(evt_valid), 32'd1);
    chk("mk_data", 32'(evt_data), 32'h21D);
    chk("mk_slot_valid", 32'(slot_valid), 32'b0001);
    chk("mk_slot0", 32'(slot_keys[8:0]), 32'h01D);
    chk("mk_held_any", 32'(held_any), 32'd1);
    send(8'hF0);
    send(8'h1D);
    chk("brk_data", 32'(evt_data), 32'h01D);
    chk("brk_slot_valid", 32'(slot_valid), 32'd0);
    chk("brk_slot0", 32'(slot_keys[8:0]), 32'd0);
    chk("brk_held_any", 32'(held_any), 32'd0);
    idle(1);
    chk("drain1_count", 32'(evt_count), 32'd0);

    // Extended make/break and query
    send(8'hE0); send(8'h75);
    chk("ext_mk_data", 32'(evt_data), 32'h375);
    query_ext = 1'b1; query_code = 8'h75; #1;
    chk("query_ext1", 32'(query_held), 32'd1);
    query_ext = 1'b0; #1;
    chk("query_ext0", 32'(query_held), 32'd0);
    query_ext = 1'b1;
    @(negedge clk);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_brk_data", 32'(evt_data), 32'h175);
    chk("query_after_brk", 32'(query_held), 32'd0);
    idle(1);

    // Slot table full, then reuse of the freed slot
    send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
    chk("tf_before", 32'(table_full), 32'd0);
    send(8'h34);
    chk("tf_pulse", 32'(table_full), 32'd1);
    chk("tf_slots", 32'(slot_valid), 32'b1111);
    idle(1);
    chk("tf_one_cycle", 32'(table_full), 32'd0);
    send(8'hF0); send(8'h1B);
    chk("tf_freed", 32'(slot_valid), 32'b1101);
    send(8'h34);
    chk("tf_reuse_valid", 32'(slot_valid), 32'b1111);
    chk("tf_reuse_key", 32'(slot_keys[17:9]), 32'h034);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h23);
    send(8'hF0); send(8'h2B); send(8'hF0); send(8'h34);
    idle(1);
    chk("tf_cleared", 32'(slot_valid), 32'd0);
    chk("tf_drain", 32'(evt_count), 32'd0);

    // FIFO overflow
    evt_ready = 1'b0;
    send(8'h15); send(8'h16); send(8'h1E); send(8'h26);
    send(8'h25); send(8'h2E); send(8'h36); send(8'h3D);
    chk("ov_count8", 32'(evt_count), 32'd8);
    chk("ov_not_yet", 32'(overflow), 32'd0);
    send(8'h3E);
    chk("ov_count_sat", 32'(evt_count), 32'd8);
    chk("ov_set", 32'(overflow), 32'd1);
    chk("ov_head", 32'(evt_data), 32'h215);
    evt_ready = 1'b1; clear_overflow = 1'b1;
    send(8'h46);
    chk("ov_pushpop_count", 32'(evt_count), 32'd8);
    chk("ov_cleared", 32'(overflow), 32'd0);
    chk("ov_new_head", 32'(evt_data), 32'h216);
    evt_ready = 1'b0;
    send(8'h45);
    chk("ov_set_wins", 32'(overflow), 32'd1);
    idle(1);
    chk("ov_clear", 32'(overflow), 32'd0);
    clear_overflow = 1'b0;
    evt_ready = 1'b1;
    idle(8);
    chk("ov_drained", 32'(evt_count), 32'd0);
    send(8'hF0); send(8'h15); send(8'hF0); send(8'h16);
    send(8'hF0); send(8'h1E); send(8'hF0); send(8'h26);
    idle(1);
    chk("ov_slots_clear", 32'(slot_valid), 32'd0);

    // Pause sequence
    evt_ready = 1'b0;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("pause_none_yet", 32'(evt_count), 32'd0);
    send(8'h77);
    chk("pause_count", 32'(evt_count), 32'd1);
    chk("pause_data", 32'(evt_data), 32'h377);
    evt_ready = 1'b1;
    send(8'hE0); send(8'hF0); send(8'h77);
    idle(1);
    chk("pause_slot_clear", 32'(slot_valid), 32'd0);

    // Prefix timeout boundary
    send(8'hE0); idle(TO - 1); send(8'h75);
    chk("tmo_just_before", 32'(evt_data), 32'h375);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); idle(TO); send(8'h1C);
    chk("tmo_expired", 32'(evt_data), 32'h21C);
    send(8'hF0); send(8'h1C);
    idle(1);

    // Dropped bytes and break-state protocol error
    evt_ready = 1'b0;
    send(8'hAA); send(8'hFA);
    chk("drop_bytes", 32'(evt_count), 32'd0);
    send(8'hF0); send(8'hE0);
    chk("brk_err_none", 32'(evt_count), 32'd0);
    send(8'h1D);
    chk("brk_err_recover", 32'(evt_data), 32'h21D);
    evt_ready = 1'b1;
    send(8'hF0); send(8'h1D);
    idle(1);

    // Typematic repeats
    evt_ready = 1'b0;
    send(8'h1C); send(8'h1C); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("typematic_count", 32'(evt_count), 32'd1);
`else
    chk("typematic_count", 32'(evt_count), 32'd3);
`endif
    chk("typematic_slots", 32'(slot_valid), 32'b0001);

    // Reset mid-sequence
    send(8'hE0); send(8'hF0);
    resetn = 1'b0; #1;
    chk("mrst_evt_valid", 32'(evt_valid), 32'd0);
    chk("mrst_evt_count", 32'(evt_count), 32'd0);
    chk("mrst_slot_valid", 32'(slot_valid), 32'd0);
    chk("mrst_slot_keys", 32'(slot_keys), 32'd0);
    chk("mrst_held_any", 32'(held_any), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    send(8'h75);
    chk("mrst_parser_idle", 32'(evt_data), 32'h275);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
